fpu_add_arbiter: RTL and testbench
==================================

FPU_ADD_ARBITER -- requirements
Module: fpu_add_arbiter

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, the operand and result width in bits.
REQ-002 The block SHALL have parameter CNTW, default 16, the completed-operation counter width.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port req_valid, input, 2: bit i set means requester i presents an operand pair.
REQ-006 Port req_ready, output, 2: bit i set means requester i's pair is accepted this cycle.
REQ-007 Ports req0_a and req0_b, input, XLEN each: requester 0 operands A and B (IEEE-754 single).
REQ-008 Ports req1_a and req1_b, input, XLEN each: requester 1 operands A and B.
REQ-009 Ports add_a and add_b, output, XLEN each: operands driven to the shared combinational FPU adder.
REQ-010 Port add_result, input, XLEN: the shared adder's sum of add_a and add_b.
REQ-011 Port rsp_valid, output, 2: bit i set means rsp_data is a result for requester i.
REQ-012 Port rsp_ready, input, 2: bit i set means requester i accepts the response.
REQ-013 Port rsp_data, output, XLEN: registered adder result.
REQ-014 Port busy, output, 1: high whenever the FSM is not in IDLE.
REQ-015 Port op_count, output, CNTW: number of completed responses.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE and RESP.
REQ-017 In IDLE, req_ready SHALL equal the one-hot grant; it SHALL be 0 in every other state.
REQ-018 The grant SHALL be round-robin: when both requesters are valid, the one not served last wins; a single valid requester always wins.
REQ-019 The last-served pointer SHALL update only on acceptance.
REQ-020 On acceptance (IDLE, req_valid[i] and req_ready[i]), the block SHALL latch the operands into add_a and add_b and store grant index i, then go to ISSUE.
REQ-021 add_a and add_b SHALL be registered outputs that change only on acceptance.
REQ-022 In ISSUE (one cycle), the block SHALL capture add_result into rsp_data and go to RESP.
REQ-023 In RESP, rsp_valid SHALL be one-hot on the stored index, and rsp_data SHALL be held stable.
REQ-024 In RESP, rsp_ready on the stored index SHALL cause a return to IDLE, and op_count SHALL increment in the same edge.
REQ-025 rsp_ready on the non-owning index SHALL be ignored.
REQ-026 Latency: acceptance at edge N gives rsp_valid high in the cycle after edge N+1, which is the minimum.
REQ-027 A new request SHALL be accepted no earlier than the cycle after the response handshake, so throughput is at most one operation per 3 cycles.
REQ-028 op_count SHALL wrap from 2^CNTW-1 to 0.
REQ-029 A request deasserted before acceptance SHALL be dropped with no side effects.
REQ-030 Operand values SHALL NOT be interpreted: NaN, Inf and denormal inputs are forwarded unchanged.

Reset
REQ-031 While rst is high at a clock edge: state becomes IDLE; req_ready, rsp_valid, busy, add_a, add_b, rsp_data and op_count become 0; the last-served pointer becomes 1, so requester 0 has first priority.
REQ-032 Reset during ISSUE or RESP SHALL abort the operation silently, with no rsp_valid pulse and no count increment.
REQ-033 rst SHALL take precedence over every simultaneous handshake.

Verification
REQ-034 Scenario, single request: after reset, req_valid=01 with req0_a=0x40400000 and req0_b=0x40800000, rsp_ready=01 -> req_ready=01 for one cycle; rsp_valid=01 with rsp_data=0x40E00000 (7.0) two edges later; op_count=1.
REQ-035 Scenario, contention: req_valid=11 held continuously with rsp_ready=11 -> grants alternate 0,1,0,1; each requester's rsp_data matches its own pair (req1: 0x3F000000+0x3F000000 -> 0x3F800000).
REQ-036 Scenario, backpressure: rsp_ready=00 for 5 cycles during RESP -> rsp_valid and rsp_data held; req_ready=00 throughout; busy=1; completes on the first cycle rsp_ready=01.
REQ-037 Scenario, wrong-owner ready: owner is 0 and rsp_ready=10 -> no state change; no op_count increment.
REQ-038 Scenario, mid-operation reset: rst is pulsed in ISSUE -> next cycle all outputs are 0; a subsequent request from requester 1 alone is served normally.
REQ-039 Scenario, counter wrap: with CNTW=2, 5 completed operations -> op_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/fpu_add_arbiter.sv
// rtl/fpu_add_arbiter.sv - two-requester round-robin front end for a shared combinational FPU adder
//
// Purpose:
//   Arbitrates two requesters onto one combinational floating-point adder.
//   An accepted operand pair is registered onto add_a/add_b. The adder sum is
//   captured one cycle later, and the response is then held until the owning
//   requester takes it. Operands are never interpreted, so NaN, Inf and
//   denormal values pass through unchanged.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   req_valid[1:0]     per-requester operand pair present
//   req_ready[1:0]     per-requester acceptance (one-hot grant while IDLE)
//   req0_a/b, req1_a/b operand pairs of requester 0 and requester 1
//   add_a, add_b       registered operands driven to the shared adder
//   add_result         combinational sum returned by the shared adder
//   rsp_valid[1:0]     one-hot response owner while in RESP
//   rsp_ready[1:0]     per-requester response acceptance
//   rsp_data           registered adder result
//   busy               high whenever an operation is in flight
//   op_count           completed responses, wrapping
module fpu_add_arbiter #(
  parameter int XLEN = 32,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  output logic [XLEN-1:0] add_a,
  output logic [XLEN-1:0] add_b,
  input  logic [XLEN-1:0] add_result,
  output logic [1:0]      rsp_valid,
  input  logic [1:0]      rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            busy,
  output logic [CNTW-1:0] op_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic            last_q, last_d;   // index of the requester served most recently
  logic            idx_q, idx_d;     // owner of the operation in flight
  logic [XLEN-1:0] add_a_q, add_a_d;
  logic [XLEN-1:0] add_b_q, add_b_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic [1:0] grant;
  logic       accept;
  logic       rsp_done;

  // With both requesters valid, the one not served last wins.
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Masking with rst keeps a handshake from appearing while reset wins the edge.
  assign req_ready = (state_q == IDLE && !rst) ? grant : 2'b00;
  assign accept    = |req_ready;
  assign rsp_done  = (state_q == RESP) && rsp_ready[idx_q];

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    idx_d      = idx_q;
    add_a_d    = add_a_q;
    add_b_d    = add_b_q;
    rsp_data_d = rsp_data_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          idx_d   = req_ready[1];
          last_d  = req_ready[1];
          add_a_d = req_ready[1] ? req1_a : req0_a;
          add_b_d = req_ready[1] ? req1_b : req0_b;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        rsp_data_d = add_result;
        state_d    = RESP;
      end
      RESP: begin
        // Ready from the non-owning requester is deliberately ignored.
        if (rsp_done) begin
          cnt_d   = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      idx_q      <= 1'b0;
      add_a_q    <= '0;
      add_b_q    <= '0;
      rsp_data_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      idx_q      <= idx_d;
      add_a_q    <= add_a_d;
      add_b_q    <= add_b_d;
      rsp_data_q <= rsp_data_d;
      cnt_q      <= cnt_d;
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_valid = (state_q == RESP) ? (idx_q ? 2'b10 : 2'b01) : 2'b00;
  assign busy      = (state_q != IDLE);
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_fpu_add_arbiter.sv
// tb/tb_fpu_add_arbiter.sv - randomized and directed self-checking bench for fpu_add_arbiter
module tb_fpu_add_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  req_valid, rsp_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;

  logic [1:0]  req_ready, rsp_valid;
  logic [31:0] add_a, add_b, add_result, rsp_data;
  logic        busy;
  logic [15:0] op_count;

  logic [1:0]  w_req_ready, w_rsp_valid;
  logic [31:0] w_add_a, w_add_b, w_add_result, w_rsp_data;
  logic        w_busy;
  logic [1:0]  w_op_count;

  int total = 0;
  int bad   = 0;

  // Stand-in for the shared adder: exact IEEE sums for the directed pairs,
  // an arbitrary deterministic mix otherwise (the arbiter never inspects values).
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40400000 && b == 32'h40800000) return 32'h40E00000;
    if (a == 32'h3F000000 && b == 32'h3F000000) return 32'h3F800000;
    return a + {b[7:0], b[31:8]} + 32'h1357_9BDF;
  endfunction

  assign add_result   = fadd(add_a, add_b);
  assign w_add_result = fadd(w_add_a, w_add_b);

  fpu_add_arbiter u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .add_a(add_a), .add_b(add_b), .add_result(add_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .op_count(op_count)
  );

  fpu_add_arbiter #(.XLEN(32), .CNTW(2)) u_wrap (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(w_req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .add_a(w_add_a), .add_b(w_add_b), .add_result(w_add_result),
    .rsp_valid(w_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(w_rsp_data),
    .busy(w_busy), .op_count(w_op_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model: one operation in flight, aged in cycles since acceptance.
  logic        m_busy  = 1'b0;
  int          m_age   = 0;
  int          m_owner = 0;
  int          m_last  = 1;
  logic [31:0] m_add_a = '0, m_add_b = '0, m_rsp = '0;
  int          m_count = 0;

  logic [1:0]  obs_rr, obs_rv;
  logic [31:0] obs_rd, obs_aa, obs_ab;
  logic        obs_busy;
  logic [15:0] obs_cnt;
  logic [1:0]  obs_wcnt;

  function automatic int winner(input logic [1:0] v);
    if (v == 2'b00) return -1;
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
    return 1 - m_last;
  endfunction

  task automatic step(input logic r, input logic [1:0] v,
                      input logic [31:0] a0, input logic [31:0] b0,
                      input logic [31:0] a1, input logic [31:0] b1,
                      input logic [1:0] rr);
    int          w;
    logic [1:0]  e_rr, e_rv;
    rst = r; req_valid = v; rsp_ready = rr;
    req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
    @(negedge clk);
    w    = winner(v);
    e_rr = (!m_busy && !r && w >= 0) ? (2'b01 << w) : 2'b00;
    e_rv = (m_busy && m_age >= 1) ? (2'b01 << m_owner) : 2'b00;
    check("req_ready", {30'd0, req_ready}, {30'd0, e_rr});
    check("rsp_valid", {30'd0, rsp_valid}, {30'd0, e_rv});
    check("rsp_data", rsp_data, m_rsp);
    check("busy", {31'd0, busy}, {31'd0, m_busy});
    check("add_a", add_a, m_add_a);
    check("add_b", add_b, m_add_b);
    check("op_count", {16'd0, op_count}, m_count % 65536);
    check("w_req_ready", {30'd0, w_req_ready}, {30'd0, e_rr});
    check("w_rsp_valid", {30'd0, w_rsp_valid}, {30'd0, e_rv});
    check("w_rsp_data", w_rsp_data, m_rsp);
    check("w_op_count", {30'd0, w_op_count}, m_count % 4);
    obs_rr = req_ready; obs_rv = rsp_valid; obs_rd = rsp_data;
    obs_aa = add_a; obs_ab = add_b; obs_busy = busy;
    obs_cnt = op_count; obs_wcnt = w_op_count;
    @(posedge clk);
    if (r) begin
      m_busy = 1'b0; m_age = 0; m_owner = 0; m_last = 1;
      m_add_a = '0; m_add_b = '0; m_rsp = '0; m_count = 0;
    end else if (!m_busy) begin
      if (w >= 0) begin
        m_busy  = 1'b1; m_age = 0; m_owner = w; m_last = w;
        m_add_a = (w == 1) ? a1 : a0;
        m_add_b = (w == 1) ? b1 : b0;
      end
    end else if (m_age == 0) begin
      m_age = 1;
      m_rsp = fadd(m_add_a, m_add_b);
    end else if (rr[m_owner]) begin
      m_busy  = 1'b0;
      m_count = m_count + 1;
    end
    #1;
  endtask

  localparam logic [31:0] A0 = 32'h40400000;
  localparam logic [31:0] B0 = 32'h40800000;
  localparam logic [31:0] H1 = 32'h3F000000;

  logic [1:0] grants[$];
  int         exp_wrap[5] = '{1, 2, 3, 0, 1};

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = '0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;

    step(1'b1, 2'b00, 0, 0, 0, 0, 2'b00);
    step(1'b1, 2'b00, 0, 0, 0, 0, 2'b00);
    step(1'b0, 2'b00, 0, 0, 0, 0, 2'b00);
    check("reset_cnt", {16'd0, obs_cnt}, 32'd0);
    check("reset_busy", {31'd0, obs_busy}, 32'd0);

    // Single request from requester 0
    step(1'b0, 2'b01, A0, B0, 0, 0, 2'b01);
    check("s1_accept", {30'd0, obs_rr}, 32'd1);
    step(1'b0, 2'b01, A0, B0, 0, 0, 2'b01);
    check("s1_issue_rdy", {30'd0, obs_rr}, 32'd0);
    check("s1_issue_rv", {30'd0, obs_rv}, 32'd0);
    step(1'b0, 2'b00, A0, B0, 0, 0, 2'b01);
    check("s1_rv", {30'd0, obs_rv}, 32'd1);
    check("s1_data", obs_rd, 32'h40E00000);
    step(1'b0, 2'b00, 0, 0, 0, 0, 2'b00);
    check("s1_count", {16'd0, obs_cnt}, 32'd1);

    // Contention: grants alternate starting at requester 0
    step(1'b1, 2'b00, 0, 0, 0, 0, 2'b00);
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 2'b11, A0, B0, H1, H1, 2'b11);
      if (obs_rr != 2'b00) grants.push_back(obs_rr);
      if (obs_rv == 2'b01) check("ct_data0", obs_rd, 32'h40E00000);
      if (obs_rv == 2'b10) check("ct_data1", obs_rd, 32'h3F800000);
    end
    check("ct_ngrants", grants.size(), 32'd4);
    for (int k = 0; k < grants.size(); k++)
      check("ct_grant", {30'd0, grants[k]}, (k % 2 == 0) ? 32'd1 : 32'd2);

    // Backpressure with wrong-owner ready mixed in
    step(1'b1, 2'b00, 0, 0, 0, 0, 2'b00);
    step(1'b0, 2'b01, A0, B0, 0, 0, 2'b00);
    step(1'b0, 2'b00, 0, 0, 0, 0, 2'b00);
    for (int k = 0; k < 7; k++) begin
      step(1'b0, 2'b11, 0, 0, H1, H1, (k % 2 == 0) ? 2'b00 : 2'b10);
      check("bp_rv", {30'd0, obs_rv}, 32'd1);
      check("bp_data", obs_rd, 32'h40E00000);
      check("bp_rdy", {30'd0, obs_rr}, 32'd0);
      check("bp_cnt", {16'd0, obs_cnt}, 32'd0);
    end
    step(1'b0, 2'b00, 0, 0, 0, 0, 2'b01);
    step(1'b0, 2'b00, 0, 0, 0, 0, 2'b00);
    check("bp_done_cnt", {16'd0, obs_cnt}, 32'd1);
    check("bp_done_busy", {31'd0, obs_busy}, 32'd0);

    // Reset pulsed during ISSUE, then requester 1 alone
    step(1'b0, 2'b01, A0, B0, 0, 0, 2'b01);
    step(1'b1, 2'b00, 0, 0, 0, 0, 2'b01);
    step(1'b0, 2'b00, 0, 0, 0, 0, 2'b01);
    check("mr_aa", obs_aa, 32'd0);
    check("mr_ab", obs_ab, 32'd0);
    check("mr_rd", obs_rd, 32'd0);
    check("mr_rv", {30'd0, obs_rv}, 32'd0);
    check("mr_cnt", {16'd0, obs_cnt}, 32'd0);
    step(1'b0, 2'b10, 0, 0, H1, H1, 2'b10);
    check("mr_accept1", {30'd0, obs_rr}, 32'd2);
    step(1'b0, 2'b00, 0, 0, 0, 0, 2'b10);
    step(1'b0, 2'b00, 0, 0, 0, 0, 2'b10);
    check("mr_rv1", {30'd0, obs_rv}, 32'd2);
    check("mr_data1", obs_rd, 32'h3F800000);

    // Counter wrap on the CNTW=2 instance
    step(1'b1, 2'b00, 0, 0, 0, 0, 2'b00);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 2'b01, A0, B0, 0, 0, 2'b01);
      step(1'b0, 2'b00, 0, 0, 0, 0, 2'b01);
      step(1'b0, 2'b00, 0, 0, 0, 0, 2'b01);
      step(1'b0, 2'b00, 0, 0, 0, 0, 2'b00);
      check("wrap_seq", {30'd0, obs_wcnt}, exp_wrap[k]);
    end

    // Randomized traffic against the model
    for (int k = 0; k < 1500; k++) begin
      step(($urandom_range(0, 63) == 0), 2'($urandom_range(0, 3)),
           $urandom, $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
